// File: rtl/intersection_phase_sched_pkg.sv
// Shared definitions for the intersection phase scheduler.
// Contents: lamp encodings, controller state enum, TRUE/FALSE constants,
//           and an index-width helper used to size the ACTIVE field.
package intersection_phase_sched_pkg;

  // Two-bit lamp code driven per approach on SIG.
  typedef enum logic [1:0] {
    LAMP_RED    = 2'b00,
    LAMP_YELLOW = 2'b01,
    LAMP_GREEN  = 2'b10
  } lamp_e;

  // Phase of the approach currently owning the right of way.
  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10
  } state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Bits needed to name one of n approaches (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intersection_phase_sched_if.sv
// Request/lamp bundle between the intersection scheduler and its environment.
// Signals: CAR_REQ      per-approach car waiting level
//          SIG          2-bit lamp per approach, approach i at SIG[2i+1:2i]
//          ACTIVE       approach owning GREEN/YELLOW (last owner in ALL_RED)
//          PHASE_CHANGE one-cycle pulse when a new approach turns GREEN
// Modports: master = sensor/observer side, slave = scheduler side.
interface intersection_phase_sched_if #(
  parameter int unsigned N_APP = 4
);

  localparam int unsigned AW = (N_APP > 1) ? $clog2(N_APP) : 1;

  logic [N_APP-1:0]   CAR_REQ;
  logic [2*N_APP-1:0] SIG;
  logic [AW-1:0]      ACTIVE;
  logic               PHASE_CHANGE;

  modport master (
    output CAR_REQ,
    input  SIG,
    input  ACTIVE,
    input  PHASE_CHANGE
  );

  modport slave (
    input  CAR_REQ,
    output SIG,
    output ACTIVE,
    output PHASE_CHANGE
  );

endinterface

// File: rtl/intersection_phase_sched_rr_pick.sv
// Combinational round-robin picker for the next green approach.
// Ports: pending  latched per-approach requests
//        owner    approach currently holding the right of way
//        valid    some approach other than owner is pending
//        winner   first pending index after owner, wrapping (owner when !valid)
module intersection_phase_sched_rr_pick
  import intersection_phase_sched_pkg::*;
#(
  parameter int unsigned N_APP = 4,
  parameter int unsigned AW    = 2
) (
  input  logic [N_APP-1:0] pending,
  input  logic [AW-1:0]    owner,
  output logic             valid,
  output logic [AW-1:0]    winner
);

  // owner + off modulo N_APP; off is always below N_APP.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base,
                                             input int unsigned   off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_APP) sum = sum - N_APP;
    return AW'(sum);
  endfunction

  // Scan farthest offset first so the nearest pending approach overwrites last.
  always_comb begin
    valid  = FALSE;
    winner = owner;
    for (int unsigned k = 1; k < N_APP; k++) begin
      if (pending[wrap_add(owner, N_APP - k)]) begin
        valid  = TRUE;
        winner = wrap_add(owner, N_APP - k);
      end
    end
  end

endmodule

// File: rtl/intersection_phase_sched.sv
// Green-time scheduler for an N-approach intersection with round-robin service.
// Latches car requests, walks one approach at a time through
// GREEN -> YELLOW -> ALL_RED, enforces min/max green, rests on green when idle.
// Ports: CLOCK  rising-edge clock
//        CLEAR  asynchronous active-high reset (approach 0 green)
//        bus    scheduler side of intersection_phase_sched_if
//               (CAR_REQ in; SIG, ACTIVE, PHASE_CHANGE out, all registered)
module intersection_phase_sched
  import intersection_phase_sched_pkg::*;
#(
  parameter int unsigned N_APP     = 4,
  parameter int unsigned TW        = 8,
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 12,
  parameter int unsigned Y_DELAY   = 3,
  parameter int unsigned R_DELAY   = 2
) (
  input logic                          CLOCK,
  input logic                          CLEAR,
  intersection_phase_sched_if.slave    bus
);

  localparam int unsigned AW = idx_width(N_APP);

  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] Y_LAST   = TW'(Y_DELAY - 1);
  localparam logic [TW-1:0] R_LAST   = TW'(R_DELAY - 1);

  state_e               state;
  logic [TW-1:0]        tmr;
  logic [N_APP-1:0]     pending;
  logic [AW-1:0]        active;
  logic [AW-1:0]        nxt;
  logic [2*N_APP-1:0]   sig;
  logic                 phase_change;

  logic [N_APP-1:0]     active_mask;
  logic [N_APP-1:0]     next_mask;
  logic [N_APP-1:0]     pending_set;
  logic                 pick_valid;
  logic [AW-1:0]        pick;
  logic                 go;

  // Lamp word with one approach at the given colour and all others red.
  function automatic logic [2*N_APP-1:0] lamp_word(input logic [AW-1:0] idx,
                                                   input lamp_e         lamp);
    logic [2*N_APP-1:0] v;
    v = '0;
    for (int i = 0; i < int'(N_APP); i++) begin
      if (AW'(i) == idx) v[2*i +: 2] = lamp;
    end
    return v;
  endfunction

  intersection_phase_sched_rr_pick #(
    .N_APP (N_APP),
    .AW    (AW)
  ) u_rr_pick (
    .pending (pending),
    .owner   (active),
    .valid   (pick_valid),
    .winner  (pick)
  );

  // One-hot decode of the current owner and the latched successor.
  always_comb begin
    active_mask = '0;
    next_mask   = '0;
    for (int i = 0; i < int'(N_APP); i++) begin
      if (AW'(i) == active) active_mask[i] = TRUE;
      if (AW'(i) == nxt)    next_mask[i]   = TRUE;
    end
  end

  // The green owner's own request never latches; it is already being served.
  always_comb begin
    pending_set = pending | (bus.CAR_REQ & ~((state == ST_GREEN) ? active_mask : '0));
  end

  // Leave green once min green is met and someone else waits, unless the
  // owner still has traffic and max green has not yet expired.
  always_comb begin
    go = (state == ST_GREEN) && (tmr >= MIN_LAST) && pick_valid &&
         (~(|(bus.CAR_REQ & active_mask)) || (tmr >= MAX_LAST));
  end

  // Phase sequencer with timer, request latch, successor latch and lamp outputs.
  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      state        <= ST_GREEN;
      tmr          <= '0;
      pending      <= '0;
      active       <= '0;
      nxt          <= '0;
      sig          <= lamp_word(AW'(0), LAMP_GREEN);
      phase_change <= FALSE;
    end else begin
      phase_change <= FALSE;
      pending      <= pending_set;
      case (state)
        ST_GREEN: begin
          if (go) begin
            state <= ST_YELLOW;
            tmr   <= '0;
            nxt   <= pick;
            sig   <= lamp_word(active, LAMP_YELLOW);
          end else if (tmr < MAX_LAST) begin
            tmr <= tmr + TW'(1);
          end
        end
        ST_YELLOW: begin
          if (tmr == Y_LAST) begin
            state <= ST_ALLRED;
            tmr   <= '0;
            sig   <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ST_ALLRED: begin
          if (tmr == R_LAST) begin
            state        <= ST_GREEN;
            tmr          <= '0;
            active       <= nxt;
            sig          <= lamp_word(nxt, LAMP_GREEN);
            phase_change <= TRUE;
            // Winner's clear beats a same-edge set; other approaches keep sets.
            pending      <= pending_set & ~next_mask;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: begin
          state <= ST_GREEN;
          tmr   <= '0;
          sig   <= lamp_word(active, LAMP_GREEN);
        end
      endcase
    end
  end

  assign bus.SIG          = sig;
  assign bus.ACTIVE       = active;
  assign bus.PHASE_CHANGE = phase_change;

endmodule

// File: tb/tb_intersection_phase_sched.sv
// Directed self-checking bench for intersection_phase_sched (4 approaches,
// min 4 / max 12 green, 3 yellow, 2 all-red). Stimulus and sampling on negedge.
module tb_intersection_phase_sched;

  logic clk;
  logic rst;

  intersection_phase_sched_if #(.N_APP(4)) bus ();

  intersection_phase_sched #(
    .N_APP     (4),
    .TW        (8),
    .MIN_GREEN (4),
    .MAX_GREEN (12),
    .Y_DELAY   (3),
    .R_DELAY   (2)
  ) dut (
    .CLOCK (clk),
    .CLEAR (rst),
    .bus   (bus)
  );

  int n_pass;
  int n_total;
  int last_green;
  bit saw_red;
  bit pc_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lamp word: one approach at code, the rest red.
  function automatic logic [7:0] lamp(input int app, input logic [1:0] code);
    logic [7:0] v;
    v = 8'h00;
    v[2*app +: 2] = code;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance to the next negedge and check the lamp safety invariant there.
  task automatic tick();
    int nonred;
    int g;
    @(negedge clk);
    nonred = 0;
    g = -1;
    for (int i = 0; i < 4; i++) begin
      if (bus.SIG[2*i +: 2] != 2'b00) nonred++;
      if (bus.SIG[2*i +: 2] == 2'b10) g = i;
    end
    chk("inv_single_lamp", 32'(nonred <= 1), 32'd1);
    if (g >= 0 && g != last_green) begin
      chk("inv_allred_before_green", 32'(saw_red), 32'd1);
      last_green = g;
      saw_red = 1'b0;
    end
    if (bus.SIG == 8'h00) saw_red = 1'b1;
    if (bus.PHASE_CHANGE) pc_seen = 1'b1;
  endtask

  task automatic clear_tracker();
    last_green = 0;
    saw_red = 1'b0;
  endtask

  // Yellow on 'from' for 3 samples, all red for 2, then 'to' green with pulse.
  task automatic expect_change(input string tag, input int from, input int to);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk({tag, "_yellow"}, 32'(bus.SIG), 32'(lamp(from, 2'b01)));
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      chk({tag, "_allred"}, 32'(bus.SIG), 32'h00);
    end
    tick();
    chk({tag, "_green"}, 32'(bus.SIG), 32'(lamp(to, 2'b10)));
    chk({tag, "_active"}, 32'(bus.ACTIVE), 32'(to));
    chk({tag, "_phase_change"}, 32'(bus.PHASE_CHANGE), 32'd1);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    pc_seen = 1'b0;
    clear_tracker();
    rst = 1'b1;
    bus.CAR_REQ = 4'b0000;

    // 1: reset, then idle rest on approach 0
    repeat (5) tick();
    chk("t1_reset_sig", 32'(bus.SIG), 32'h02);
    chk("t1_reset_active", 32'(bus.ACTIVE), 32'd0);
    chk("t1_reset_pc", 32'(bus.PHASE_CHANGE), 32'd0);
    rst = 1'b0;
    pc_seen = 1'b0;
    repeat (50) tick();
    chk("t1_idle_sig", 32'(bus.SIG), 32'h02);
    chk("t1_idle_active", 32'(bus.ACTIVE), 32'd0);
    chk("t1_idle_no_pc", 32'(pc_seen), 32'd0);

    // 2: one-cycle request on approach 2 after min green met
    bus.CAR_REQ = 4'b0100;
    tick();
    chk("t2_still_green", 32'(bus.SIG), 32'h02);
    bus.CAR_REQ = 4'b0000;
    expect_change("t2", 0, 2);
    tick();
    chk("t2_pc_one_cycle", 32'(bus.PHASE_CHANGE), 32'd0);
    chk("t2_green_holds", 32'(bus.SIG), 32'h20);
    repeat (20) tick();
    chk("t2_rest_sig", 32'(bus.SIG), 32'h20);
    chk("t2_rest_active", 32'(bus.ACTIVE), 32'd2);

    // 3: approach 0 holds its request -> capped at 12 green cycles
    bus.CAR_REQ = 4'b0001;
    repeat (6) tick();
    chk("t3_allred_before_app0", 32'(bus.SIG), 32'h00);
    tick();
    chk("t3_app0_green", 32'(bus.SIG), 32'h02);
    chk("t3_app0_pc", 32'(bus.PHASE_CHANGE), 32'd1);
    bus.CAR_REQ = 4'b0011;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk("t3_max_green_hold", 32'(bus.SIG), 32'h02);
    end
    tick();
    chk("t3_yellow_after_12", 32'(bus.SIG), 32'h01);
    bus.CAR_REQ = 4'b0000;
    repeat (2) begin
      tick();
      chk("t3_yellow", 32'(bus.SIG), 32'h01);
    end
    repeat (2) begin
      tick();
      chk("t3_allred", 32'(bus.SIG), 32'h00);
    end
    tick();
    chk("t3_app1_green", 32'(bus.SIG), 32'h08);
    chk("t3_app1_active", 32'(bus.ACTIVE), 32'd1);
    chk("t3_app1_pc", 32'(bus.PHASE_CHANGE), 32'd1);

    // 4: requests 1..3 together from approach 0 -> served 1,2,3 at min green
    rst = 1'b1;
    clear_tracker();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("t4_pre_sig", 32'(bus.SIG), 32'h02);
    chk("t4_pre_active", 32'(bus.ACTIVE), 32'd0);
    bus.CAR_REQ = 4'b1110;
    tick();
    chk("t4_still_green", 32'(bus.SIG), 32'h02);
    bus.CAR_REQ = 4'b0000;
    expect_change("t4_0to1", 0, 1);
    repeat (3) begin
      tick();
      chk("t4_app1_hold", 32'(bus.SIG), 32'h08);
    end
    expect_change("t4_1to2", 1, 2);
    repeat (3) begin
      tick();
      chk("t4_app2_hold", 32'(bus.SIG), 32'h20);
    end
    expect_change("t4_2to3", 2, 3);

    // 5: CLEAR in the second yellow cycle of approach 2 wipes pending
    repeat (5) tick();
    chk("t5_app3_rest", 32'(bus.SIG), 32'h80);
    bus.CAR_REQ = 4'b0100;
    tick();
    chk("t5_app3_still", 32'(bus.SIG), 32'h80);
    bus.CAR_REQ = 4'b0000;
    expect_change("t5_3to2", 3, 2);
    repeat (5) tick();
    bus.CAR_REQ = 4'b0010;
    tick();
    chk("t5_app2_green", 32'(bus.SIG), 32'h20);
    bus.CAR_REQ = 4'b1000;
    tick();
    chk("t5_yellow1", 32'(bus.SIG), 32'h10);
    bus.CAR_REQ = 4'b0000;
    tick();
    chk("t5_yellow2", 32'(bus.SIG), 32'h10);
    rst = 1'b1;
    clear_tracker();
    #1;
    chk("t5_clear_sig", 32'(bus.SIG), 32'h02);
    chk("t5_clear_active", 32'(bus.ACTIVE), 32'd0);
    chk("t5_clear_pc", 32'(bus.PHASE_CHANGE), 32'd0);
    tick();
    rst = 1'b0;
    pc_seen = 1'b0;
    repeat (30) tick();
    chk("t5_pending_wiped_sig", 32'(bus.SIG), 32'h02);
    chk("t5_pending_wiped_pc", 32'(pc_seen), 32'd0);

    // 6: request at timer 1 waits for min green before yellow
    rst = 1'b1;
    clear_tracker();
    tick();
    rst = 1'b0;
    tick();
    bus.CAR_REQ = 4'b1000;
    tick();
    chk("t6_green_t2", 32'(bus.SIG), 32'h02);
    bus.CAR_REQ = 4'b0000;
    tick();
    chk("t6_green_t3", 32'(bus.SIG), 32'h02);
    expect_change("t6_0to3", 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
